// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end.
// Two raw active-low pushbuttons are synchronized and debounced into single-cycle
// press events. A run/pause/idle FSM acts on those events and drives count_enable
// (prescaled tick) and sync_clr (one-cycle clear) into the downstream BCD counter chain.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_stop_n,
    input  logic clear_n,
    output logic count_enable,
    output logic sync_clr,
    output logic running,
    output logic paused
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    // The counter flips the level on the cycle it would reach DEBOUNCE_CYCLES.
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    // Bit 0: start/stop button, bit 1: clear button.
    logic [1:0] btn_raw;
    logic [1:0] press_evt;

    assign btn_raw = {clear_n, start_stop_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          press_reg;
            logic [DW-1:0] cnt_reg;

            // Two-flop synchronizer, debounce counter and press-edge detector.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        // Only the released->pressed transition is an event.
                        press_reg <= ~sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_evt[gi] = press_reg;
        end
    endgenerate

    logic start_evt;
    logic clear_evt;
    logic presc_adv;

    state_t        state_reg;
    logic [PW-1:0] presc_reg;

    assign start_evt = press_evt[0];
    assign clear_evt = press_evt[1];

    // The prescaler advances on every cycle that ends in RUNNING, except the entry
    // from IDLE; the pause edge does not count but the resume edge does, so the
    // partial tick is carried across a pause.
    assign presc_adv = ((state_reg == ST_RUNNING) && !start_evt) ||
                       ((state_reg == ST_PAUSED)  &&  start_evt);

    // Run/pause/idle FSM with prescaler and registered outputs; clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            presc_reg    <= '0;
            count_enable <= 1'b0;
            sync_clr     <= 1'b1;
            running      <= 1'b0;
            paused       <= 1'b0;
        end else begin
            count_enable <= 1'b0;
            sync_clr     <= 1'b0;
            if (clear_evt) begin
                state_reg <= ST_IDLE;
                presc_reg <= '0;
                sync_clr  <= 1'b1;
                running   <= 1'b0;
                paused    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_evt) begin
                            state_reg <= ST_RUNNING;
                            running   <= 1'b1;
                            paused    <= 1'b0;
                        end
                    end
                    ST_RUNNING: begin
                        if (start_evt) begin
                            state_reg <= ST_PAUSED;
                            running   <= 1'b0;
                            paused    <= 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (start_evt) begin
                            state_reg <= ST_RUNNING;
                            running   <= 1'b1;
                            paused    <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        running   <= 1'b0;
                        paused    <= 1'b0;
                    end
                endcase
                if (presc_adv) begin
                    if (presc_reg == PRESC_LAST) begin
                        presc_reg    <= '0;
                        count_enable <= 1'b1;
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Outputs are observed 1 time unit after each rising edge as {running, paused, count_enable, sync_clr}.
module tb_stopwatch_ctrl;

    logic clk          = 1'b0;
    logic reset_n      = 1'b1;
    logic start_stop_n = 1'b1;
    logic clear_n      = 1'b1;
    logic count_enable;
    logic sync_clr;
    logic running;
    logic paused;
    logic [3:0] obs;
    logic [3:0] exp_v;

    int checks    = 0;
    int failures  = 0;
    int edge_n    = 0;
    int run_entry = 0;

    stopwatch_ctrl #(
        .TICK_DIV       (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_stop_n(start_stop_n),
        .clear_n     (clear_n),
        .count_enable(count_enable),
        .sync_clr    (sync_clr),
        .running     (running),
        .paused      (paused)
    );

    always #5 clk = ~clk;

    assign obs = {running, paused, count_enable, sync_clr};

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0001) begin
            failures++;
            $display("FAIL reset_async edge=%0d got=%b exp=%b", edge_n, obs, 4'b0001);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== 4'b0001) begin
                failures++;
                $display("FAIL reset_hold edge=%0d got=%b exp=%b", edge_n, obs, 4'b0001);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL reset_release edge=%0d got=%b exp=%b", edge_n, obs, 4'b0000);
            end
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    // Hold start: enter RUNNING 6 edges after first low sample, ticks every 5 edges,
    // then release and a 3-cycle bounce that must be ignored.
    task automatic test_start_hold();
        int n0;
        start_stop_n = 1'b0;
        n0 = edge_n + 1;
        while (edge_n < n0 + 5) begin
            step();
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL start_early edge=%0d got=%b exp=%b", edge_n, obs, 4'b0000);
            end
        end
        step();
        checks++;
        if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL start_enter edge=%0d got=%b exp=%b", edge_n, obs, 4'b1000);
        end
        run_entry = edge_n;
        for (int k = 1; k <= 32; k++) begin
            if (k == 17) start_stop_n = 1'b1;
            if (k == 25) start_stop_n = 1'b0;
            if (k == 28) start_stop_n = 1'b1;
            step();
            exp_v = {1'b1, 1'b0, (k % 5 == 0), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL run_tick k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        $display("test_start_hold done checks=%0d", checks);
    endtask

    // Pause at prescaler count 3 (pause event at entry+39), resume at entry+57,
    // next tick one edge after resume, then every 5.
    task automatic test_pause_resume();
        for (int k = 33; k <= 70; k++) begin
            if (k == 33) start_stop_n = 1'b0;
            if (k == 43) start_stop_n = 1'b1;
            if (k == 51) start_stop_n = 1'b0;
            if (k == 57) start_stop_n = 1'b1;
            step();
            if (k < 39)
                exp_v = {1'b1, 1'b0, (k % 5 == 0), 1'b0};
            else if (k < 57)
                exp_v = 4'b0100;
            else if (k == 57)
                exp_v = 4'b1000;
            else
                exp_v = {1'b1, 1'b0, ((k - 58) % 5 == 0), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL pause_resume k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        $display("test_pause_resume done checks=%0d", checks);
    endtask

    // Clear lands on a wrap edge: sync_clr wins, count_enable stays 0; the next
    // start gives its first tick 5 edges after entry.
    task automatic test_clear_running();
        for (int j = 1; j <= 32; j++) begin
            if (j == 2)  clear_n = 1'b0;
            if (j == 12) clear_n = 1'b1;
            if (j == 21) start_stop_n = 1'b0;
            if (j == 27) start_stop_n = 1'b1;
            step();
            if (j < 8)
                exp_v = {1'b1, 1'b0, (j == 3), 1'b0};
            else if (j == 8)
                exp_v = 4'b0001;
            else if (j < 27)
                exp_v = 4'b0000;
            else
                exp_v = {1'b1, 1'b0, (j == 32), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clear_run j=%0d got=%b exp=%b", j, obs, exp_v);
            end
        end
        $display("test_clear_running done checks=%0d", checks);
    endtask

    // Start and clear dropped on the same edge: clear wins, FSM ends in IDLE.
    task automatic test_simultaneous();
        for (int j = 1; j <= 20; j++) begin
            if (j == 1) begin
                start_stop_n = 1'b0;
                clear_n      = 1'b0;
            end
            if (j == 9) begin
                start_stop_n = 1'b1;
                clear_n      = 1'b1;
            end
            step();
            if (j < 7)
                exp_v = {1'b1, 1'b0, (j == 5), 1'b0};
            else if (j == 7)
                exp_v = 4'b0001;
            else
                exp_v = 4'b0000;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL simul j=%0d got=%b exp=%b", j, obs, exp_v);
            end
        end
        $display("test_simultaneous done checks=%0d", checks);
    endtask

    // Reset asserted between edges while count_enable is high must clear outputs at once.
    task automatic test_async_reset();
        for (int j = 1; j <= 12; j++) begin
            if (j == 1) start_stop_n = 1'b0;
            if (j == 7) start_stop_n = 1'b1;
            step();
            if (j < 7)
                exp_v = 4'b0000;
            else
                exp_v = {1'b1, 1'b0, (j == 12), 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL async_run j=%0d got=%b exp=%b", j, obs, exp_v);
            end
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0001) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", obs, 4'b0001);
        end
        step();
        checks++;
        if (obs !== 4'b0001) begin
            failures++;
            $display("FAIL async_reset_hold got=%b exp=%b", obs, 4'b0001);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL async_reset_release got=%b exp=%b", obs, 4'b0000);
            end
        end
        $display("test_async_reset done checks=%0d", checks);
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_pause_resume();
        test_clear_running();
        test_simultaneous();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached at edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

endmodule
